// File: rtl/dot_sprite_drawer.sv
// Scanline reader for the 16x16 dot sprite ROM: latches the dot position per frame,
// fetches the matching sprite row per line and shifts it out as a per-pixel is_dot flag.
module dot_sprite_drawer #(
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 16,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                pix_en,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [9:0]          DotX,
  input  logic [9:0]          DotY,
  input  logic                dot_enable,
  input  logic                dot_clear,
  output logic                clear_ack,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                is_dot,
  output logic                dot_visible
);

  localparam int unsigned CntW = $clog2(SPRITE_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ARMED = 2'd2;
  localparam logic [1:0] SHIFT = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [9:0]          dot_x_q, dot_x_d;
  logic [9:0]          dot_y_q, dot_y_d;
  logic                en_q, en_d;
  logic                hidden_q, hidden_d;
  logic                clear_pend_q, clear_pend_d;
  logic                clear_ack_q, clear_ack_d;
  logic                dot_visible_q, dot_visible_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [SPRITE_W-1:0] line_reg_q, line_reg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                is_dot_q, is_dot_d;

  logic [9:0]          row_off;
  logic                row_hit;
  logic                clear_take;

  // Frame-level state: shadow position, clear handshake and visibility
  always_comb begin
    clear_take   = frame_start & (clear_pend_q | dot_clear);
    dot_x_d      = dot_x_q;
    dot_y_d      = dot_y_q;
    en_d         = en_q;
    hidden_d     = hidden_q;
    clear_pend_d = clear_pend_q | dot_clear;
    clear_ack_d  = clear_take;
    if (frame_start) begin
      dot_x_d = DotX;
      dot_y_d = DotY;
      en_d    = dot_enable;
      if (clear_take) begin
        hidden_d     = 1'b1;
        clear_pend_d = 1'b0;
      end else if (!dot_enable) begin
        hidden_d = 1'b0;
      end
    end
    // Computed from next-state values so visibility tracks the frame latch edge
    dot_visible_d = en_d & ~hidden_d;
  end

  // Unsigned row offset; DotY_s above DrawY is a miss, never a wrap
  always_comb begin
    row_off = DrawY - dot_y_q;
    row_hit = dot_visible_q && (DrawY >= dot_y_q) && (row_off < 10'(SPRITE_H));
  end

  // Line FSM: fetch the row, wait for DotX_s, then shift SPRITE_W pixels MSB first
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    line_reg_d = line_reg_q;
    cnt_d      = cnt_q;
    is_dot_d   = is_dot_q;
    if (frame_start) begin
      state_d  = IDLE;
      is_dot_d = 1'b0;
    end else if (line_start) begin
      is_dot_d = 1'b0;
      if (row_hit) begin
        state_d    = FETCH;
        rom_addr_d = row_off[ADDR_W-1:0];
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pix_en) is_dot_d = 1'b0;
        end
        FETCH: begin
          line_reg_d = rom_data;
          state_d    = ARMED;
          if (pix_en) is_dot_d = 1'b0;
        end
        ARMED: begin
          if (pix_en) begin
            if (DrawX == dot_x_q) begin
              is_dot_d   = line_reg_q[SPRITE_W-1];
              line_reg_d = line_reg_q << 1;
              cnt_d      = CntW'(1);
              state_d    = SHIFT;
            end else begin
              is_dot_d = 1'b0;
            end
          end
        end
        SHIFT: begin
          if (pix_en) begin
            is_dot_d   = line_reg_q[SPRITE_W-1];
            line_reg_d = line_reg_q << 1;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == CntW'(SPRITE_W - 1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      dot_x_q       <= '0;
      dot_y_q       <= '0;
      en_q          <= 1'b0;
      hidden_q      <= 1'b0;
      clear_pend_q  <= 1'b0;
      clear_ack_q   <= 1'b0;
      dot_visible_q <= 1'b0;
      rom_addr_q    <= '0;
      line_reg_q    <= '0;
      cnt_q         <= '0;
      is_dot_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      dot_x_q       <= dot_x_d;
      dot_y_q       <= dot_y_d;
      en_q          <= en_d;
      hidden_q      <= hidden_d;
      clear_pend_q  <= clear_pend_d;
      clear_ack_q   <= clear_ack_d;
      dot_visible_q <= dot_visible_d;
      rom_addr_q    <= rom_addr_d;
      line_reg_q    <= line_reg_d;
      cnt_q         <= cnt_d;
      is_dot_q      <= is_dot_d;
    end
  end

  assign clear_ack   = clear_ack_q;
  assign rom_addr    = rom_addr_q;
  assign is_dot      = is_dot_q;
  assign dot_visible = dot_visible_q;

endmodule

// File: tb/tb_dot_sprite_drawer.sv
// Scoreboard bench for dot_sprite_drawer: per-pixel is_dot expectations are queued by the
// stimulus and popped by a monitor one clock after each pix_en cycle.
module tb_dot_sprite_drawer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start, line_start, pix_en, dot_enable, dot_clear;
  logic [9:0]  DrawX, DrawY, DotX, DotY;
  logic        clear_ack, is_dot, dot_visible;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;

  int checks   = 0;
  int failures = 0;
  int ones     = 0;
  logic exp_q[$];
  logic pix_d = 1'b0;

  // Bench-side copy of the frame state used to predict pixels
  int       m_dx, m_dy;
  bit       m_vis, m_hidden, m_pend;
  int       m_addr;

  always #5 Clk = ~Clk;

  dot_sprite_drawer #(.SPRITE_W(16), .SPRITE_H(16), .ADDR_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .line_start(line_start),
    .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY), .DotX(DotX), .DotY(DotY),
    .dot_enable(dot_enable), .dot_clear(dot_clear), .clear_ack(clear_ack),
    .rom_addr(rom_addr), .rom_data(rom_data), .is_dot(is_dot), .dot_visible(dot_visible)
  );

  function automatic logic [15:0] rom_row(input logic [5:0] a);
    case (a[3:0])
      4'd0:  rom_row = 16'h8001;  4'd1:  rom_row = 16'h4002;
      4'd2:  rom_row = 16'h2004;  4'd3:  rom_row = 16'h1008;
      4'd4:  rom_row = 16'h0810;  4'd5:  rom_row = 16'h0420;
      4'd6:  rom_row = 16'h0180;  4'd7:  rom_row = 16'h03C0;
      4'd8:  rom_row = 16'h03C0;  4'd9:  rom_row = 16'h0180;
      4'd10: rom_row = 16'h0420;  4'd11: rom_row = 16'h0810;
      4'd12: rom_row = 16'h1008;  4'd13: rom_row = 16'h2004;
      4'd14: rom_row = 16'h4002;  default: rom_row = 16'hC003;
    endcase
  endfunction

  assign rom_data = rom_row(rom_addr);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one is_dot sample per pix_en cycle, taken on the falling edge
  always @(posedge Clk) pix_d <= pix_en & ~Reset;
  always @(negedge Clk) begin
    if (pix_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: is_dot=%0b with no expectation queued", is_dot);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (is_dot !== e) begin
          failures++;
          $display("FAIL is_dot: got %0b expected %0b at %0t", is_dot, e, $time);
        end
      end
      if (is_dot === 1'b1) ones++;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_frame(input int dx, input int dy, input bit en, input bit clr);
    bit ack;
    DotX = 10'(dx); DotY = 10'(dy); dot_enable = en; dot_clear = clr; frame_start = 1'b1;
    ack   = m_pend | clr;
    m_dx  = dx;
    m_dy  = dy;
    if (ack) m_hidden = 1'b1;
    else if (!en) m_hidden = 1'b0;
    m_pend = 1'b0;
    m_vis  = en & ~m_hidden;
    step();
    frame_start = 1'b0; dot_clear = 1'b0;
    check("clear_ack_pulse", int'(clear_ack), int'(ack));
    step();
    check("clear_ack_low", int'(clear_ack), 0);
    check("dot_visible", int'(dot_visible), int'(m_vis));
  endtask

  function automatic logic model_pix(input int y, input int x);
    logic [15:0] r;
    if (!m_vis || y < m_dy || y - m_dy >= 16 || x < m_dx || x - m_dx >= 16) return 1'b0;
    r = rom_row(6'(y - m_dy));
    return r[15 - (x - m_dx)];
  endfunction

  task automatic drive_pixels(input int y, input int x0, input int x1, input bit half);
    for (int x = x0; x <= x1; x++) begin
      pix_en = 1'b1; DrawX = 10'(x);
      exp_q.push_back(model_pix(y, x));
      step();
      if (half) begin
        pix_en = 1'b0;
        step();
      end
    end
    pix_en = 1'b0;
  endtask

  task automatic start_line(input int y, input bit clr_mid);
    line_start = 1'b1; DrawY = 10'(y);
    if (clr_mid) begin
      dot_clear = 1'b1;
      m_pend    = 1'b1;
    end
    if (m_vis && y >= m_dy && y - m_dy < 16) m_addr = y - m_dy;
    step();
    line_start = 1'b0; dot_clear = 1'b0;
    step();
    step();
    ones = 0;
  endtask

  task automatic do_line(input int y, input int x0, input int x1, input bit half,
                         input int exp_ones, input bit clr_mid);
    start_line(y, clr_mid);
    drive_pixels(y, x0, x1, half);
    step();
    step();
    check($sformatf("ones_line%0d", y), ones, exp_ones);
    check($sformatf("rom_addr_line%0d", y), int'(rom_addr), m_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; frame_start = 0; line_start = 0; pix_en = 0; dot_enable = 0; dot_clear = 0;
    DrawX = 0; DrawY = 0; DotX = 0; DotY = 0;
    m_dx = 0; m_dy = 0; m_vis = 0; m_hidden = 0; m_pend = 0; m_addr = 0;
    step();
    step();
    check("rst_is_dot", int'(is_dot), 0);
    check("rst_clear_ack", int'(clear_ack), 0);
    check("rst_dot_visible", int'(dot_visible), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    Reset = 1'b0;
    step();

    // Dot at (100,200): row hits, misses above and below the sprite
    do_frame(100, 200, 1'b1, 1'b0);
    do_line(199, 95, 120, 1'b0, 0, 1'b0);
    do_line(206, 95, 120, 1'b0, 2, 1'b0);
    do_line(207, 95, 120, 1'b0, 4, 1'b1);   // clear request mid-frame
    do_line(208, 95, 120, 1'b1, 4, 1'b0);   // still drawn, half-rate pixels
    do_line(215, 90, 120, 1'b0, 4, 1'b0);
    do_line(216, 95, 120, 1'b0, 0, 1'b0);

    // Clear applies at the next frame, then disable/enable re-arms
    do_frame(100, 200, 1'b1, 1'b0);
    do_line(207, 95, 120, 1'b0, 0, 1'b0);
    do_frame(100, 200, 1'b0, 1'b0);
    do_frame(100, 200, 1'b1, 1'b0);
    do_line(207, 95, 120, 1'b0, 4, 1'b0);

    // Clear coinciding with frame_start takes effect at that frame
    do_frame(100, 200, 1'b1, 1'b1);
    do_line(207, 95, 120, 1'b0, 0, 1'b0);
    do_frame(100, 200, 1'b0, 1'b0);

    // Mid-frame move: new DotX is ignored until the next frame
    do_frame(100, 200, 1'b1, 1'b0);
    do_line(203, 95, 120, 1'b0, 2, 1'b0);
    DotX = 10'd300;
    do_line(204, 95, 120, 1'b1, 2, 1'b0);
    do_frame(300, 200, 1'b1, 1'b0);
    do_line(207, 295, 320, 1'b0, 4, 1'b0);

    // Right edge truncation, no spill into the following line
    do_frame(630, 200, 1'b1, 1'b0);
    do_line(207, 620, 639, 1'b0, 4, 1'b0);
    do_line(208, 0, 5, 1'b0, 0, 1'b0);
    do_line(200, 625, 639, 1'b0, 1, 1'b0);
    do_line(201, 0, 7, 1'b0, 0, 1'b0);

    // Bottom edge: rows 0..9 on lines 470..479, no wrap to the next frame
    do_frame(100, 470, 1'b1, 1'b0);
    for (int y = 470; y <= 479; y++) do_line(y, 95, 120, 1'b0, (y == 477 || y == 478) ? 4 : 2, 1'b0);
    do_frame(100, 470, 1'b1, 1'b0);
    do_line(0, 95, 120, 1'b0, 0, 1'b0);
    do_line(1, 95, 120, 1'b0, 0, 1'b0);

    // Reset in the middle of SHIFT
    do_frame(100, 200, 1'b1, 1'b0);
    start_line(207, 1'b0);
    drive_pixels(207, 98, 107, 1'b0);
    @(negedge Clk);
    #1;
    check("pre_reset_is_dot", int'(is_dot), 1);
    Reset = 1'b1;
    #1;
    check("mid_rst_is_dot", int'(is_dot), 0);
    check("mid_rst_dot_visible", int'(dot_visible), 0);
    check("mid_rst_rom_addr", int'(rom_addr), 0);
    check("mid_rst_clear_ack", int'(clear_ack), 0);
    exp_q.delete();
    m_dx = 0; m_dy = 0; m_vis = 0; m_hidden = 0; m_pend = 0; m_addr = 0;
    step();
    Reset = 1'b0;
    step();
    do_line(207, 95, 120, 1'b0, 0, 1'b0);
    do_line(0, 0, 20, 1'b0, 0, 1'b0);
    do_frame(100, 200, 1'b1, 1'b0);
    do_line(207, 95, 120, 1'b0, 4, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_sprite_drawer.md
# dot_sprite_drawer

Scanline reader for the 16x16 dot sprite ROM. Per frame it latches one dot position. Per line it fetches the matching sprite row from the ROM over the ROM's address/data port, then shifts that row out as a per-pixel `is_dot` flag aligned to the VGA pixel stream. It sits between the VGA controller (DrawX/DrawY, line/frame strobes) and the color mapper. It also supports a "collected" clear handshake so game logic can hide the dot at a frame boundary.

## Interface
- `SPRITE_W`, 16: sprite width in pixels, equal to the ROM data width.
- `SPRITE_H`, 16: sprite height in rows.
- `ADDR_W`, 6: ROM address width.
- `Clk` in 1: system clock. One clock domain.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_start` in 1: 1-cycle pulse at start of frame.
- `line_start` in 1: 1-cycle pulse before the first pixel of each line.
- `pix_en` in 1: pixel strobe; DrawX/DrawY are valid in this cycle.
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current line. Valid at `line_start` for the upcoming line.
- `DotX`, `DotY` in 10 each: dot top-left corner.
- `dot_enable` in 1: dot exists.
- `dot_clear` in 1: request to hide the dot (level or pulse).
- `clear_ack` out 1: 1-cycle pulse when a clear takes effect.
- `rom_addr` out ADDR_W: sprite row address. Combinational ROM, data in the same cycle.
- `rom_data` in 16: sprite row. Bit 15 is the leftmost pixel.
- `is_dot` out 1: current pixel belongs to the dot.
- `dot_visible` out 1: dot is drawn this frame.

## Operation
- Frame latch, on `frame_start`:
  - Shadow registers take `DotX_s <= DotX`, `DotY_s <= DotY`, `en_s <= dot_enable`.
  - Input changes mid-frame have no effect until the next `frame_start`.
- Clear handshake:
  - `dot_clear` sets `clear_pend` in any cycle.
  - At `frame_start` with `clear_pend`: set `hidden`, clear `clear_pend`, pulse `clear_ack` the next cycle.
  - At `frame_start` with `dot_enable == 0`: clear `hidden` (re-arm).
  - If `dot_clear` and `frame_start` coincide, the clear applies at this frame_start.
  - `dot_visible = en_s & ~hidden`, registered.
- Line FSM states: IDLE, FETCH, ARMED, SHIFT.
  - IDLE -> FETCH on `line_start` when `dot_visible` and `DrawY >= DotY_s` and `DrawY - DotY_s < SPRITE_H`.
    - Unsigned 10-bit compare. No wrap-around: DotY_s > DrawY means no hit.
    - `rom_addr <= DrawY - DotY_s`, zero-extended and registered. It holds its last value otherwise.
  - FETCH -> ARMED after 1 cycle; `line_reg <= rom_data`.
  - ARMED -> SHIFT on `pix_en` with `DrawX == DotX_s`. Emit `line_reg[15]`, set `cnt = 1`.
  - SHIFT: each `pix_en` emits `line_reg[15 - cnt]` and increments `cnt`. After emitting with `cnt == 15`, go to IDLE.
  - `line_start` in any state restarts evaluation from IDLE; the same cycle may enter FETCH.
  - `frame_start` forces IDLE.
- `is_dot` is 0 in IDLE, FETCH and ARMED, and whenever the emitted bit is 0.
- Right-edge truncation: a line ending mid-sprite is cut off by `line_start`. Pixels never spill into the next line.
- If DotX_s is never reached, the FSM stays ARMED until `line_start`.

## Timing
- Reset values:
  - Outputs: `is_dot = 0`, `clear_ack = 0`, `dot_visible = 0`, `rom_addr = 0`.
  - Internal state: FSM IDLE, shadow registers 0, `hidden = 0`, `clear_pend = 0`.
  - Reset mid-line aborts immediately.
- `is_dot` is registered on the clock edge ending the `pix_en` cycle for DrawX = DotX_s + k. It is valid from the next cycle through the cycle of the following `pix_en`, so latency is 1 clock.
- `line_start` must precede the first `pix_en` at DrawX == DotX_s by at least 2 clocks. A match during FETCH is lost.
- `clear_ack` is high exactly 1 cycle, the cycle after the applying `frame_start`.
- `pix_en` may be high every cycle or at a 1/2 rate. The FSM only advances on `pix_en`.

## Test plan
- Reset: assert Reset mid-SHIFT -> all outputs 0 immediately, FSM IDLE, and no `is_dot` until the next frame_start plus a hit.
- Dot at (100,200), enabled:
  - Line 207 (row 7 = 0x03C0) -> `is_dot` for DrawX 106..109 only.
  - Line 206 (0x0180) -> 107, 108.
  - Lines 199 and 216 -> no FETCH, `rom_addr` unchanged, `is_dot` never 1.
- Clear:
  - Pulse `dot_clear` at line 207 -> the rest of the frame still draws.
  - Next `frame_start` -> `clear_ack` 1-cycle pulse, `dot_visible = 0`, no `is_dot`.
  - `dot_enable = 0` at one frame_start, then 1 at the next -> visible again.
- Right edge: DotX = 630, 640-wide line, row 7 -> `is_dot` at 636..639. After `line_start`, DrawX 0..3 of the next line stay 0.
- Mid-frame move: change DotX 100 -> 300 at line 203 -> lines 203..215 still draw at 100; the next frame draws at 300.
- Bottom edge: DotY = 470 -> rows 0..9 fetched on lines 470..479; no wrap to line 0 of the next frame.
